mem_port_arbiter: RTL

Sequential arbiter that shares one single-ported unified memory between the pipeline's instruction-fetch path and the load/store unit. Fetch and LSU raise requests; the block grants one at a time and drives a registered req/ack memory handshake. It returns read data to the owning requester and reports `busy` to the hazard unit for stall generation. Data requests have priority, with a bounded streak counter so fetch cannot starve.

---
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request, grant and memory handshake signals shared by the fetch path, the LSU and the memory port.
// The slave modport is the arbiter's view; master is the surrounding pipeline and memory.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        ls_req;
  logic        ls_we;
  logic [3:0]  ls_mask;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_mask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_mask, ls_addr, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_we, mem_mask, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_mask, ls_addr, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_we, mem_mask, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the LSU, one transaction at a time.
// Data wins contention, but a bounded streak of data wins forces fetch through so it cannot starve.
module mem_port_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_streak;
  logic [3:0]  w_next_streak;
  logic        w_grant_if;
  logic        w_grant_ls;
  logic        w_ack;

  logic        r_if_gnt;
  logic        r_if_rvalid;
  logic [31:0] r_if_rdata;
  logic        r_ls_gnt;
  logic        r_ls_rvalid;
  logic [31:0] r_ls_rdata;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [3:0]  r_mem_mask;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  // Streak only grows while fetch is actually waiting, so it can never pass STREAK_MAX.
  always_comb begin
    w_next_state  = r_state;
    w_next_streak = r_streak;
    w_grant_if    = 1'b0;
    w_grant_ls    = 1'b0;
    w_ack         = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.ls_req && (!bus.if_req || (r_streak < STREAK_MAX))) begin
          w_grant_ls    = 1'b1;
          w_next_state  = DATA;
          w_next_streak = bus.if_req ? (r_streak + 4'd1) : 4'd0;
        end else if (bus.if_req) begin
          w_grant_if    = 1'b1;
          w_next_state  = FETCH;
          w_next_streak = 4'd0;
        end
      end
      FETCH, DATA: begin
        if (bus.mem_ack) begin
          w_ack        = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_streak <= 4'd0;
    end else begin
      r_state  <= w_next_state;
      r_streak <= w_next_streak;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= 32'd0;
      r_ls_gnt    <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_ls_rdata  <= 32'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_mask  <= 4'd0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      r_if_gnt    <= w_grant_if;
      r_ls_gnt    <= w_grant_ls;
      r_if_rvalid <= w_ack && (r_state == FETCH);
      r_ls_rvalid <= w_ack && (r_state == DATA);

      if (w_grant_if) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_mask  <= 4'hF;
        r_mem_addr  <= bus.if_addr;
        r_mem_wdata <= 32'd0;
      end else if (w_grant_ls) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= bus.ls_we;
        r_mem_mask  <= bus.ls_mask;
        r_mem_addr  <= bus.ls_addr;
        r_mem_wdata <= bus.ls_wdata;
      end else if (w_ack) begin
        r_mem_req   <= 1'b0;
      end

      // The held mem_we still identifies a store at completion time; stores return zero.
      if (w_ack && (r_state == FETCH)) begin
        r_if_rdata <= bus.mem_rdata;
      end
      if (w_ack && (r_state == DATA)) begin
        r_ls_rdata <= r_mem_we ? 32'd0 : bus.mem_rdata;
      end
    end
  end

  assign bus.if_gnt    = r_if_gnt;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.ls_gnt    = r_ls_gnt;
  assign bus.ls_rvalid = r_ls_rvalid;
  assign bus.ls_rdata  = r_ls_rdata;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_mask  = r_mem_mask;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign busy          = (r_state != IDLE);

endmodule
